// File: rtl/regfile_pkg.sv
// Shared constants and encodings for the register-file writeback arbiter.
// Contents: default widths, register count, FSM state and round-robin pointer
// encodings used by regfile_wb_arbiter and regfile_wen_decoder.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  // Writable registers 1..31; register 0 is hard-wired zero.
  localparam int NREG   = 31;

  // One-hot state encoding; the two remaining encodings are illegal and
  // steer the FSM back to ST_INIT.
  typedef enum logic [1:0] {
    ST_INIT = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  // Round-robin pointer: the requester that wins the next contested cycle.
  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_e;

endpackage

// File: rtl/regfile_wen_decoder.sv
// Register address to one-hot write-enable decoder (combinational).
// Ports: addr (ADDR_W) in; wen (NREG) out, bit k-1 set for register k,
// all zero for register 0.
module regfile_wen_decoder
  import regfile_pkg::NREG;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NREG-1:0]   wen
);

  always_comb begin
    wen = '0;
    for (int k = 1; k <= NREG; k++) begin
      wen[k-1] = (addr == ADDR_W'(k));
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: clears registers 1..31 after reset, then
// round-robin arbitrates ALU (A) and load (B) writebacks, one write per cycle.
// Ports: clk/rst_n; a_/b_ valid, addr, data, ready; registered wr_en/wr_addr/
// wr_data (latency 1 from acceptance); busy while clearing.
module regfile_wb_arbiter
  import regfile_pkg::NREG;
  import regfile_pkg::state_e;
  import regfile_pkg::ST_INIT;
  import regfile_pkg::ST_RUN;
  import regfile_pkg::rr_e;
  import regfile_pkg::RR_A;
  import regfile_pkg::RR_B;
#(
  parameter int DATA_W     = regfile_pkg::DATA_W,
  parameter int ADDR_W     = regfile_pkg::ADDR_W,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [NREG-1:0]   wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREG);
  localparam state_e            RST_ST   = INIT_CLEAR ? ST_INIT : ST_RUN;

  state_e              state_q, state_d;
  rr_e                 rr_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                a_xfer, b_xfer;
  logic [ADDR_W-1:0]   mux_addr;
  logic [DATA_W-1:0]   mux_data;
  logic [NREG-1:0]     dec_wen;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_ST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and grant logic. Readies are also masked by rst_n so they read
  // 0 while reset is asserted even when the FSM resets straight into ST_RUN.
  always_comb begin
    state_d = ST_INIT;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_d = (cnt_q == LAST_REG) ? ST_RUN : ST_INIT;
      end
      ST_RUN: begin
        state_d = ST_RUN;
        a_ready = rst_n & (~b_valid | (rr_q == RR_A));
        b_ready = rst_n & (~a_valid | (rr_q == RR_B));
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign busy   = (state_q == ST_INIT);
  assign a_xfer = a_valid & a_ready;
  assign b_xfer = b_valid & b_ready;

  // Single decoder shared between the clear counter and the granted request.
  always_comb begin
    mux_addr = a_addr;
    mux_data = a_data;
    if (state_q == ST_INIT) begin
      mux_addr = cnt_q;
      mux_data = '0;
    end else if (b_xfer) begin
      mux_addr = b_addr;
      mux_data = b_data;
    end
  end

  regfile_wen_decoder #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr (mux_addr),
    .wen  (dec_wen)
  );

  // Write port, clear counter and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      cnt_q   <= ADDR_W'(1);
      rr_q    <= RR_A;
    end else begin
      case (state_q)
        ST_INIT: begin
          wr_en   <= dec_wen;
          wr_addr <= mux_addr;
          wr_data <= mux_data;
          // Hold at the last register instead of wrapping to 0.
          if (cnt_q != LAST_REG) begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          if (a_xfer | b_xfer) begin
            // Address 0 decodes to no enable, so the write is dropped while
            // wr_addr/wr_data still reflect the accepted request.
            wr_en   <= dec_wen;
            wr_addr <= mux_addr;
            wr_data <= mux_data;
          end else begin
            wr_en <= '0;
          end
          // Pointer moves only on contention, to the loser.
          if (a_valid & b_valid) begin
            rr_q <= a_xfer ? RR_B : RR_A;
          end
        end
        default: begin
          wr_en <= '0;
          cnt_q <= ADDR_W'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic [30:0] wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .INIT_CLEAR (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .b_ready (b_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        ear;
    logic        ebr;
    logic [30:0] een;
    logic [4:0]  eaddr;
    logic [31:0] edata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [4:0] aa, logic [31:0] ad,
                              logic bv, logic [4:0] ba, logic [31:0] bd,
                              logic ear, logic ebr, logic [30:0] een,
                              logic [4:0] eaddr, logic [31:0] edata);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd;
    v.ear = ear; v.ebr = ebr;
    v.een = een; v.eaddr = eaddr; v.edata = edata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_noz(input string name);
    total++;
    if ($isunknown({a_ready, b_ready, wr_en, wr_addr, wr_data, busy})) begin
      bad++;
      $display("FAIL %s: X/Z on outputs en=%h addr=%h data=%h", name, wr_en, wr_addr, wr_data);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  // Checks a full clear sequence starting from a freshly released reset.
  task automatic check_init();
    chk("init_busy_pre", {31'd0, busy}, 32'd1);
    chk("init_ardy_pre", {31'd0, a_ready}, 32'd0);
    for (int k = 1; k <= 31; k++) begin
      step();
      chk($sformatf("init_en_%0d", k), {1'b0, wr_en}, 32'd1 << (k - 1));
      chk($sformatf("init_addr_%0d", k), {27'd0, wr_addr}, k);
      chk($sformatf("init_data_%0d", k), wr_data, 32'd0);
      chk($sformatf("init_busy_%0d", k), {31'd0, busy}, (k < 31) ? 32'd1 : 32'd0);
      chk($sformatf("init_rdy_%0d", k), {30'd0, a_ready, b_ready}, (k < 31) ? 32'd0 : 32'd3);
    end
    step();
    chk("init_done_en", {1'b0, wr_en}, 32'd0);
    chk("init_done_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vectors applied once INIT has finished and rr_ptr points at A.
    vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0, 32'h0,  1, 0, 31'h0000_0010, 5,  32'hDEADBEEF));
    vecs.push_back(mk(1, 3,  32'h11,       1, 7, 32'h22, 1, 0, 31'h0000_0004, 3,  32'h11));
    vecs.push_back(mk(1, 3,  32'h11,       1, 7, 32'h22, 0, 1, 31'h0000_0040, 7,  32'h22));
    vecs.push_back(mk(1, 3,  32'h11,       1, 7, 32'h22, 1, 0, 31'h0000_0004, 3,  32'h11));
    vecs.push_back(mk(1, 3,  32'h11,       1, 7, 32'h22, 0, 1, 31'h0000_0040, 7,  32'h22));
    vecs.push_back(mk(0, 0,  32'h0,        1, 0, 32'h55, 1, 1, 31'h0,         0,  32'h55));
    vecs.push_back(mk(1, 3,  32'h11,       1, 7, 32'h22, 1, 0, 31'h0000_0004, 3,  32'h11));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0, 32'h0,  1, 1, 31'h0,         3,  32'h11));
    vecs.push_back(mk(1, 31, 32'hFFFFFFFF, 0, 0, 32'h0,  1, 1, 31'h4000_0000, 31, 32'hFFFFFFFF));
    vecs.push_back(mk(0, 0,  32'h0,        1, 1, 32'hAB, 0, 1, 31'h0000_0001, 1,  32'hAB));
    vecs.push_back(mk(1, 2,  32'h33,       1, 4, 32'h44, 0, 1, 31'h0000_0008, 4,  32'h44));
    vecs.push_back(mk(1, 2,  32'h33,       1, 4, 32'h44, 1, 0, 31'h0000_0002, 2,  32'h33));

    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_en", {1'b0, wr_en}, 32'd0);
    chk("rst_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_data", wr_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rdy", {30'd0, a_ready, b_ready}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #(-2 + 2);

    // Reset asserted mid-clear, right after register 9 was issued (cnt=10).
    for (int k = 1; k <= 9; k++) step();
    chk("mid_init_en_before", {1'b0, wr_en}, 32'd1 << 8);
    rst_n = 1'b0;
    #1;
    chk("mid_init_rst_en", {1'b0, wr_en}, 32'd0);
    chk("mid_init_rst_addr", {27'd0, wr_addr}, 32'd0);
    chk("mid_init_rst_data", wr_data, 32'd0);
    chk("mid_init_rst_busy", {31'd0, busy}, 32'd1);
    #1;
    rst_n = 1'b1;

    // Full clear sequence must restart from register 1.
    check_init();

    // Table-driven RUN vectors.
    foreach (vecs[i]) begin
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      #1;
      chk($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].ear});
      chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].ebr});
      step();
      idle_inputs();
      chk($sformatf("v%0d_wr_en", i), {1'b0, wr_en}, {1'b0, vecs[i].een});
      chk($sformatf("v%0d_wr_addr", i), {27'd0, wr_addr}, {27'd0, vecs[i].eaddr});
      chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].edata);
      chk_noz($sformatf("v%0d_noX", i));
    end

    // rr_ptr now points at B. Reset mid-RUN with a contested request pending:
    // the in-flight write is discarded and the pointer returns to A.
    a_valid = 1'b1; a_addr = 5'd9;  a_data = 32'h99;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hAA;
    #1;
    chk("run_pre_rst_b_ready", {31'd0, b_ready}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("run_rst_en", {1'b0, wr_en}, 32'd0);
    chk("run_rst_rdy", {30'd0, a_ready, b_ready}, 32'd0);
    chk("run_rst_busy", {31'd0, busy}, 32'd1);
    idle_inputs();
    step();
    chk("run_rst_hold_en", {1'b0, wr_en}, 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) step();
    chk("rerun_busy", {31'd0, busy}, 32'd0);
    a_valid = 1'b1; a_addr = 5'd9;  a_data = 32'h99;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hAA;
    #1;
    chk("rerun_a_ready", {31'd0, a_ready}, 32'd1);
    chk("rerun_b_ready", {31'd0, b_ready}, 32'd0);
    step();
    idle_inputs();
    chk("rerun_wr_en", {1'b0, wr_en}, 32'h0000_0100);
    chk("rerun_wr_data", wr_data, 32'h99);
    chk_noz("rerun_noX");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
